serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  controller can accept an operand set.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: sum  output  WIDTH  result sum bits.
REQ-012 Port: cout  output  1  final carry-out.

Function
REQ-013 The block SHALL compute a+b+cin bit-serially, LSB first, through one 1-bit full-adder instance, one bit per clock.
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 On accept, the block SHALL load a, b and cin into internal shift/carry registers, clear the bit counter and go to RUN.
REQ-017 Each RUN cycle SHALL add the current LSBs plus the carry register, shift the sum bit into sum MSB-first-in, shift the operands right, register the carry and increment the counter.
REQ-018 At the edge where counter == WIDTH-1, the FSM SHALL go to DONE; out_valid SHALL rise exactly WIDTH cycles after the accept edge.
REQ-019 In DONE, out_valid=1 and sum/cout SHALL be held stable until out_ready=1; on that edge the FSM SHALL go to IDLE.
REQ-020 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap during an operation.
REQ-021 in_valid in RUN/DONE SHALL be ignored, and a/b/cin changes after accept SHALL not affect the result.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 After DONE->IDLE, a new accept SHALL be possible on the next cycle, giving throughput of one result per WIDTH+2 cycles minimum.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, clear the counter, operand registers and carry, and set in_ready=1, out_valid=0, sum=0, cout=0 (and ovf=0 when present).
REQ-025 rst asserted mid-RUN or mid-DONE SHALL abort the operation without emitting a result.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined: add port ovf  output  1  signed two's-complement overflow = carry into MSB XOR carry out of MSB, valid with out_valid.
REQ-027 Macro SERIAL_ADD_OVF_EN undefined: port ovf and its carry-into-MSB register SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 The bit datapath SHALL be one instance of the team's 1-bit full-adder sub-module fullAdder; the FSM, counter and shift registers SHALL stay in serial_add_ctrl.

Verification (WIDTH=8)
REQ-030 a=0x12, b=0x34, cin=0, accept -> out_valid 8 cycles later, sum=0x46, cout=0.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0 (when enabled).
REQ-032 a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1 (when enabled); a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
REQ-033 Accept, hold out_ready=0 for 5 cycles in DONE, and drive in_valid plus new operands meanwhile -> sum stable, in_ready=0, no second accept; then out_ready=1 -> IDLE next cycle.
REQ-034 Assert rst asynchronously 3 cycles into RUN -> outputs cleared immediately, no out_valid; next accept a=0x0F, b=0xF0, cin=1 -> sum=0x00, cout=1.
REQ-035 Run back-to-back random operands with out_ready=1 for 1000 operations -> every result matches a+b+cin, and each result is spaced exactly WIDTH+2 cycles from the previous one.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM encoding and default width for the serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int WIDTH_DEF = 8;
endpackage

// File: rtl/fullAdder.sv
// fullAdder: 1-bit full adder used as the serial datapath
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial a+b+cin, LSB first, one bit per clock through a single fullAdder
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ra, rb;
  logic c, s, co, last;
`ifdef SERIAL_ADD_OVF_EN
  logic cmsb;
  assign ovf = cmsb ^ cout;
`endif
  fullAdder u_fa (.a(ra[0]), .b(rb[0]), .cin(c), .sum(s), .cout(co));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ra        <= '0;
      rb        <= '0;
      c         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      cmsb      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b;
          c        <= cin;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          sum <= {s, sum[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= co;
          // counter stops at WIDTH-1 so it never wraps for power-of-two widths
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= co;
`ifdef SERIAL_ADD_OVF_EN
            cmsb      <= c;
`endif
          end else cnt <= cnt + CW'(1);
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and back-to-back checks of serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin = 0;
  logic in_ready, out_valid, cout, ovf;
  logic [7:0] a = 0, b = 0, sum;
  int checks = 0, errors = 0, cyc = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
`ifndef SERIAL_ADD_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout got %b want 1", in_ready);
    end
    in_valid = 1; a = ia; b = ib; cin = ic;
    @(posedge clk); #1;
    in_valid = 0; a = ~ia; b = ~ib; cin = ~ic;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic release_result();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 00 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] va [4] = '{8'h12, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [4] = '{8'h34, 8'h01, 8'h01, 8'h80};
    logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] es [4] = '{8'h46, 8'h00, 8'h80, 8'h01};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      op(va[i], vb[i], vc[i], lat);
      checks++;
      if (lat !== 8) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d want 8", i, lat);
      end
      checks++;
      if ({cout, sum} !== {ec[i], es[i]}) begin
        errors++;
        $display("FAIL basic_result[%0d] got cout=%b sum=%h want cout=%b sum=%h", i, cout, sum, ec[i], es[i]);
      end
`ifdef SERIAL_ADD_OVF_EN
      checks++;
      if (ovf !== eo[i]) begin
        errors++;
        $display("FAIL basic_ovf[%0d] got %b want %b", i, ovf, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unexpected x");
`endif
      release_result();
    end
  endtask

  task automatic test_hold();
    int lat;
    out_ready = 1;
    op(8'h21, 8'h43, 1'b1, lat);
    out_ready = 0;
    checks++;
    if ({out_valid, sum, cout} !== {1'b1, 8'h65, 1'b0}) begin
      errors++;
      $display("FAIL hold_first got vld=%b sum=%h cout=%b want 1 65 0", out_valid, sum, cout);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 8'(i * 17); b = 8'hA5; cin = 1;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sum, cout} !== {1'b1, 1'b0, 8'h65, 1'b0}) begin
        errors++;
        $display("FAIL hold_stable[%0d] got vld=%b rdy=%b sum=%h cout=%b want 1 0 65 0",
                 i, out_valid, in_ready, sum, cout);
      end
    end
    in_valid = 0;
    release_result();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic seen = 0;
    in_valid = 1; a = 8'h55; b = 8'h66; cin = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_clear got rdy=%b vld=%b sum=%h cout=%b ovf=%b want 1 0 00 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    @(posedge clk); #3 rst = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result got out_valid seen=%b want 0", seen);
    end
    op(8'h0F, 8'hF0, 1'b1, lat);
    checks++;
    if ({lat == 8, cout, sum} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL abort_next got lat=%0d cout=%b sum=%h want lat=8 cout=1 sum=00", lat, cout, sum);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] exp;
    int n, last_cyc = -1;
    out_ready = 1;
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      in_valid = 1; a = ra; b = rb; cin = rc;
      @(posedge clk); #1;
      a = ~ra; b = ~rb;
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if ({cout, sum} !== exp) begin
        errors++;
        $display("FAIL b2b_result[%0d] got %h want %h", k, {cout, sum}, exp);
      end
      if (last_cyc >= 0) begin
        checks++;
        if (cyc - last_cyc !== 10) begin
          errors++;
          $display("FAIL b2b_spacing[%0d] got %0d want 10", k, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
